// File: rtl/reg_write_port.sv
// reg_write_port: write side of the 16 x DATA_W register bank.
// ALU results enter an in-order write queue over a valid/ready handshake and
// are committed into the register array one per cycle while wb_en is high.
// Both read ports bypass pending queue entries (youngest match wins), so a
// read always observes the newest value written to a register.

module reg_write_port #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [3:0]                 wr_dest,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       wb_en,
    input  logic [3:0]                 src1_sel,
    output logic [DATA_W-1:0]          src1_data,
    input  logic [3:0]                 src2_sel,
    output logic [DATA_W-1:0]          src2_data,
    output logic [15:0]                commit_onehot,
    output logic [15:0]                pending,
    output logic [$clog2(DEPTH):0]     count
);

    // DEPTH is 2 or 4, so pointers wrap naturally at PTR_W bits.
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] regs_r     [16];
    logic [3:0]        q_dest_r   [DEPTH];
    logic [DATA_W-1:0] q_data_r   [DEPTH];
    logic [DEPTH-1:0]  q_valid_r;
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;

    logic              accept_s;
    logic              commit_s;

    // Read one register through the queue bypass. Entries are walked from
    // oldest (head) to youngest, so the last match is the youngest one and
    // overrides both older matches and the committed register value. Only
    // stored entries take part; the incoming wr_* request never does.
    function automatic logic [DATA_W-1:0] read_port(input logic [3:0] sel);
        logic [DATA_W-1:0] val;
        logic [PTR_W-1:0]  idx;
        val = regs_r[sel];
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_r + PTR_W'(k);
            if (q_valid_r[idx] && (q_dest_r[idx] == sel)) begin
                val = q_data_r[idx];
            end else begin
                val = val;
            end
        end
        return val;
    endfunction

    // wr_ready is a pure function of occupancy; there is no pass-through
    // when full, even if a commit frees a slot on the same edge.
    assign wr_ready = (count_r < CNT_W'(DEPTH));
    assign accept_s = wr_valid && wr_ready;
    assign commit_s = wb_en && (count_r != {CNT_W{1'b0}});
    assign count    = count_r;

    // Queue storage, pointers and occupancy; accept and commit may coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_dest_r[i] <= 4'h0;
                q_data_r[i] <= {DATA_W{1'b0}};
            end
            q_valid_r <= {DEPTH{1'b0}};
            head_r    <= {PTR_W{1'b0}};
            tail_r    <= {PTR_W{1'b0}};
            count_r   <= {CNT_W{1'b0}};
        end else begin
            if (accept_s) begin
                q_dest_r[tail_r]  <= wr_dest;
                q_data_r[tail_r]  <= wr_data;
                q_valid_r[tail_r] <= 1'b1;
                tail_r            <= tail_r + PTR_W'(1'b1);
            end
            // head != tail whenever a commit and an accept coincide, because
            // commit needs count > 0 and accept needs count < DEPTH.
            if (commit_s) begin
                q_valid_r[head_r] <= 1'b0;
                head_r            <= head_r + PTR_W'(1'b1);
            end
            case ({accept_s, commit_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Register array: the head entry lands in its destination on a commit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (commit_s) begin
            regs_r[q_dest_r[head_r]] <= q_data_r[head_r];
        end
    end

    // One-hot enable of the register being written on the coming edge.
    always_comb begin
        commit_onehot = 16'h0000;
        if (commit_s) begin
            commit_onehot = 16'h0001 << q_dest_r[head_r];
        end else begin
            commit_onehot = 16'h0000;
        end
    end

    // Pending mask rebuilt from the valid queue entries every cycle.
    always_comb begin
        pending = 16'h0000;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_valid_r[i]) begin
                pending = pending | (16'h0001 << q_dest_r[i]);
            end else begin
                pending = pending;
            end
        end
    end

    // Two independent combinational read ports with queue bypass.
    always_comb begin
        src1_data = read_port(src1_sel);
        src2_data = read_port(src2_sel);
    end

endmodule

// File: tb/tb_reg_write_port.sv
// Bench for reg_write_port: a table of per-cycle vectors with hand-derived
// expectations, a queue-based reference scoreboard checked every cycle, and
// a hand-written asynchronous-reset sequence.

module tb_reg_write_port;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;
    localparam int NVEC   = 22;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_valid;
    logic              wr_ready;
    logic [3:0]        wr_dest;
    logic [31:0]       wr_data;
    logic              wb_en;
    logic [3:0]        src1_sel;
    logic [31:0]       src1_data;
    logic [3:0]        src2_sel;
    logic [31:0]       src2_data;
    logic [15:0]       commit_onehot;
    logic [15:0]       pending;
    logic [1:0]        count;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        wv;
        logic [3:0]  wd;
        logic [31:0] wdat;
        logic        wb;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [3:0]  cnt;
        logic        rdy;
        logic [15:0] pend;
        logic [15:0] oh;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    typedef struct packed {
        logic [3:0]  d;
        logic [31:0] v;
    } ent_t;

    vec_t        vecs [NVEC];
    ent_t        sb_q [$];
    logic [31:0] m_regs [16];

    reg_write_port #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_dest       (wr_dest),
        .wr_data       (wr_data),
        .wb_en         (wb_en),
        .src1_sel      (src1_sel),
        .src1_data     (src1_data),
        .src2_sel      (src2_sel),
        .src2_data     (src2_data),
        .commit_onehot (commit_onehot),
        .pending       (pending),
        .count         (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sv(input int i, input logic wv, input logic [3:0] wd, input logic [31:0] wdat,
                      input logic wb, input logic [3:0] s1, input logic [3:0] s2,
                      input logic [3:0] cnt, input logic rdy, input logic [15:0] pend,
                      input logic [15:0] oh, input logic [31:0] e1, input logic [31:0] e2);
        vecs[i].wv = wv;   vecs[i].wd = wd;   vecs[i].wdat = wdat; vecs[i].wb = wb;
        vecs[i].s1 = s1;   vecs[i].s2 = s2;   vecs[i].cnt = cnt;   vecs[i].rdy = rdy;
        vecs[i].pend = pend; vecs[i].oh = oh; vecs[i].e1 = e1;     vecs[i].e2 = e2;
    endtask

    // Reference read: committed value, overridden by queued writes, youngest last.
    function automatic logic [31:0] m_read(input logic [3:0] sel);
        logic [31:0] val;
        val = m_regs[sel];
        foreach (sb_q[k]) if (sb_q[k].d == sel) val = sb_q[k].v;
        return val;
    endfunction

    function automatic logic [15:0] m_pending();
        logic [15:0] p;
        p = 16'h0000;
        foreach (sb_q[k]) p[sb_q[k].d] = 1'b1;
        return p;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
        sb_q.delete();
    endtask

    // Drive one vector, check table and scoreboard mid-cycle, then clock it in.
    task automatic apply(input int i);
        logic acc;
        logic com;
        ent_t e;
        wr_valid = vecs[i].wv; wr_dest = vecs[i].wd; wr_data = vecs[i].wdat;
        wb_en = vecs[i].wb; src1_sel = vecs[i].s1; src2_sel = vecs[i].s2;
        #2;
        chk($sformatf("v%0d count", i),   {30'h0, count},          {28'h0, vecs[i].cnt});
        chk($sformatf("v%0d ready", i),   {31'h0, wr_ready},       {31'h0, vecs[i].rdy});
        chk($sformatf("v%0d pending", i), {16'h0, pending},        {16'h0, vecs[i].pend});
        chk($sformatf("v%0d onehot", i),  {16'h0, commit_onehot},  {16'h0, vecs[i].oh});
        chk($sformatf("v%0d src1", i),    src1_data,               vecs[i].e1);
        chk($sformatf("v%0d src2", i),    src2_data,               vecs[i].e2);
        // Scoreboard: independent reference of the same cycle.
        chk($sformatf("sb%0d src1", i),    src1_data, m_read(src1_sel));
        chk($sformatf("sb%0d src2", i),    src2_data, m_read(src2_sel));
        chk($sformatf("sb%0d pending", i), {16'h0, pending}, {16'h0, m_pending()});
        acc = wr_valid && (sb_q.size() < DEPTH);
        com = wb_en && (sb_q.size() > 0);
        if (com) begin
            e = sb_q.pop_front();
            chk($sformatf("sb%0d commit", i), {16'h0, commit_onehot}, {16'h0, 16'h0001 << e.d});
            m_regs[e.d] = e.v;
        end else begin
            chk($sformatf("sb%0d nocommit", i), {16'h0, commit_onehot}, 32'h0);
        end
        if (acc) begin
            e.d = wr_dest;
            e.v = wr_data;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_dest = 4'h0; wr_data = 32'h0;
        wb_en = 1'b0; src1_sel = 4'h0; src2_sel = 4'h0;
        m_clear();

        //   i  wv wd  wdat          wb s1 s2  cnt rdy pend      oh        e1            e2
        sv(0,  0, 0, 32'h0,        0, 1, 15, 0, 1, 16'h0000, 16'h0000, 32'h0,        32'h0);
        sv(1,  1, 5, 32'hDEADBEEF, 1, 5, 5,  0, 1, 16'h0000, 16'h0000, 32'h0,        32'h0);
        sv(2,  0, 0, 32'h0,        1, 5, 0,  1, 1, 16'h0020, 16'h0020, 32'hDEADBEEF, 32'h0);
        sv(3,  0, 0, 32'h0,        0, 5, 5,  0, 1, 16'h0000, 16'h0000, 32'hDEADBEEF, 32'hDEADBEEF);
        sv(4,  1, 1, 32'h1,        0, 1, 2,  0, 1, 16'h0000, 16'h0000, 32'h0,        32'h0);
        sv(5,  1, 2, 32'h2,        0, 1, 2,  1, 1, 16'h0002, 16'h0000, 32'h1,        32'h0);
        sv(6,  1, 3, 32'h3,        0, 1, 3,  2, 0, 16'h0006, 16'h0000, 32'h1,        32'h0);
        sv(7,  1, 3, 32'h3,        1, 2, 3,  2, 0, 16'h0006, 16'h0002, 32'h2,        32'h0);
        sv(8,  1, 3, 32'h3,        1, 1, 3,  1, 1, 16'h0004, 16'h0004, 32'h1,        32'h0);
        sv(9,  0, 0, 32'h0,        1, 3, 2,  1, 1, 16'h0008, 16'h0008, 32'h3,        32'h2);
        sv(10, 0, 0, 32'h0,        0, 3, 1,  0, 1, 16'h0000, 16'h0000, 32'h3,        32'h1);
        sv(11, 1, 3, 32'h11,       0, 3, 3,  0, 1, 16'h0000, 16'h0000, 32'h3,        32'h3);
        sv(12, 1, 3, 32'h22,       0, 3, 3,  1, 1, 16'h0008, 16'h0000, 32'h11,       32'h11);
        sv(13, 0, 0, 32'h0,        1, 3, 3,  2, 0, 16'h0008, 16'h0008, 32'h22,       32'h22);
        sv(14, 0, 0, 32'h0,        1, 3, 3,  1, 1, 16'h0008, 16'h0008, 32'h22,       32'h22);
        sv(15, 0, 0, 32'h0,        0, 3, 3,  0, 1, 16'h0000, 16'h0000, 32'h22,       32'h22);
        sv(16, 1, 4, 32'h44,       0, 4, 9,  0, 1, 16'h0000, 16'h0000, 32'h0,        32'h0);
        sv(17, 1, 9, 32'h99,       1, 4, 9,  1, 1, 16'h0010, 16'h0010, 32'h44,       32'h0);
        sv(18, 0, 0, 32'h0,        1, 4, 9,  1, 1, 16'h0200, 16'h0200, 32'h44,       32'h99);
        sv(19, 0, 0, 32'h0,        0, 9, 4,  0, 1, 16'h0000, 16'h0000, 32'h99,       32'h44);
        sv(20, 1, 7, 32'hA5A5A5A5, 0, 7, 5,  0, 1, 16'h0000, 16'h0000, 32'h0,        32'hDEADBEEF);
        sv(21, 1, 7, 32'hA5A5A5A5, 0, 7, 5,  1, 1, 16'h0080, 16'h0000, 32'hA5A5A5A5, 32'hDEADBEEF);

        // Reset state, every select on both ports.
        #3;
        for (int s = 0; s < 16; s++) begin
            src1_sel = s[3:0];
            src2_sel = 4'(15 - s);
            #1;
            chk($sformatf("rst src1 sel%0d", s), src1_data, 32'h0);
            chk($sformatf("rst src2 sel%0d", 15 - s), src2_data, 32'h0);
        end
        chk("rst ready",   {31'h0, wr_ready}, 32'h1);
        chk("rst count",   {30'h0, count}, 32'h0);
        chk("rst pending", {16'h0, pending}, 32'h0);
        chk("rst onehot",  {16'h0, commit_onehot}, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        for (int i = 0; i < NVEC; i++) apply(i);

        // Queue is full of dest 7 entries; reset mid-cycle must discard them.
        wr_valid = 1'b0; wb_en = 1'b0; src1_sel = 4'd7; src2_sel = 4'd5;
        #1;
        chk("full count", {30'h0, count}, 32'h2);
        chk("full ready", {31'h0, wr_ready}, 32'h0);
        rst_n = 1'b0;
        m_clear();
        #1;
        chk("async count",   {30'h0, count}, 32'h0);
        chk("async pending", {16'h0, pending}, 32'h0);
        chk("async src1",    src1_data, 32'h0);
        chk("async src2",    src2_data, 32'h0);
        chk("async ready",   {31'h0, wr_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        wb_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #2;
            chk($sformatf("post-rst onehot c%0d", c), {16'h0, commit_onehot}, 32'h0);
            chk($sformatf("post-rst count c%0d", c),  {30'h0, count}, 32'h0);
            chk($sformatf("post-rst src1 c%0d", c),   src1_data, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
